// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: write-back arbiter for the single integer register file
// write port. Grants one requester per cycle and drives the register file from
// one registered stage. Writes to x0 are granted but suppressed.
// Build option: define WB_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority applies and the lowest index wins.
module regfile_wb_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_LENGTH = 5,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ADDR_LENGTH-1:0] req_addr,
  input  logic [NUM_REQ*WORD_LENGTH-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           wb_hold,
  output logic                           rf_write_en,
  output logic [ADDR_LENGTH-1:0]         rf_write_addr,
  output logic [WORD_LENGTH-1:0]         rf_data,
  output logic [CNT_WIDTH-1:0]           conflict_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // True when two or more requesters compete in the same cycle.
  function automatic logic multi_req(input logic [NUM_REQ-1:0] v);
    return $countones(v) >= 2;
  endfunction

  logic                   sel_found;
  logic [IDX_W-1:0]       sel_idx;
  logic                   xfer;
  logic [ADDR_LENGTH-1:0] sel_addr;
  logic [WORD_LENGTH-1:0] sel_data;

  logic                   wb_vld_p1;
  logic [ADDR_LENGTH-1:0] wb_addr_p1;
  logic [WORD_LENGTH-1:0] wb_data_p1;
  logic [CNT_WIDTH-1:0]   conflict_cnt_r;

  // ---- stage p0: arbitration ----
`ifdef WB_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr_p0;

  // Round robin: lowest valid index at or above the pointer, else lowest valid overall.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i >= int'(rr_ptr_p0))) begin
        sel_idx = IDX_W'(i);
      end
    end
  end

  // Pointer moves just past the winner, only when a transfer happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_p0 <= '0;
    end else if (xfer) begin
      rr_ptr_p0 <= (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
    end
  end
`else
  // Fixed priority: the lowest valid index wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end
`endif

  // One-hot grant, suppressed during reset and write-back hold.
  always_comb begin
    req_ready = '0;
    if (!rst && !wb_hold && sel_found) begin
      req_ready[sel_idx] = 1'b1;
    end
  end

  assign xfer = |req_ready;

  // Route the granted requester's address and data toward the output stage.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_addr = req_addr[i*ADDR_LENGTH +: ADDR_LENGTH];
        sel_data = req_data[i*WORD_LENGTH +: WORD_LENGTH];
      end
    end
  end

  // ---- stage p1: register file write stage ----
  // Capture the transfer; x0 targets keep the enable low, idle cycles hold addr/data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_vld_p1  <= 1'b0;
      wb_addr_p1 <= '0;
      wb_data_p1 <= '0;
    end else if (xfer) begin
      wb_vld_p1  <= |sel_addr;
      wb_addr_p1 <= sel_addr;
      wb_data_p1 <= sel_data;
    end else begin
      wb_vld_p1  <= 1'b0;
    end
  end

  // Saturating count of contended cycles, independent of hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt_r <= '0;
    end else if (multi_req(req_valid)) begin
      conflict_cnt_r <= sat_inc(conflict_cnt_r);
    end
  end

  assign rf_write_en   = wb_vld_p1;
  assign rf_write_addr = wb_addr_p1;
  assign rf_data       = wb_data_p1;
  assign conflict_cnt  = conflict_cnt_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a table of per-cycle vectors with the expected
// grant, a scoreboard queue of expected register file writes, and hand-written
// sequences for reset behaviour and counter saturation. A second instance with
// a 4-bit conflict counter shares all inputs.
module tb_regfile_wb_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   req_valid = '0;
  logic [14:0]  req_addr = '0;
  logic [95:0]  req_data = '0;
  logic         wb_hold = 1'b0;

  logic [2:0]   req_ready, rdy_s;
  logic         rf_write_en, en_s;
  logic [4:0]   rf_write_addr, addr_s;
  logic [31:0]  rf_data, data_s;
  logic [15:0]  conflict_cnt;
  logic [3:0]   cnt_s;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_REQ(3), .WORD_LENGTH(32), .ADDR_LENGTH(5), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .wb_hold(wb_hold), .rf_write_en(rf_write_en),
    .rf_write_addr(rf_write_addr), .rf_data(rf_data), .conflict_cnt(conflict_cnt)
  );

  regfile_wb_arbiter #(.NUM_REQ(3), .WORD_LENGTH(32), .ADDR_LENGTH(5), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(rdy_s), .wb_hold(wb_hold), .rf_write_en(en_s),
    .rf_write_addr(addr_s), .rf_data(data_s), .conflict_cnt(cnt_s)
  );

  typedef struct {
    logic [2:0]  v;
    logic        hold;
    logic [14:0] a;
    logic [95:0] d;
    logic [2:0]  rdy;
    string       name;
  } vec_t;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } out_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];
  out_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [4:0]  last_addr = '0;
  logic [31:0] last_data = '0;
  int exp_cnt = 0;
  int exp_cnt4 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] v, input logic hold,
                              input logic [4:0] a2, input logic [4:0] a1, input logic [4:0] a0,
                              input logic [31:0] d2, input logic [31:0] d1, input logic [31:0] d0,
                              input logic [2:0] rdy, input string name);
    vec_t t;
    t.v = v; t.hold = hold; t.a = {a2, a1, a0}; t.d = {d2, d1, d0}; t.rdy = rdy; t.name = name;
    return t;
  endfunction

  task automatic model_reset();
    last_addr = '0;
    last_data = '0;
    exp_cnt   = 0;
    exp_cnt4  = 0;
    exp_q.delete();
  endtask

  // Drive one cycle starting just after a rising edge; check grant mid-cycle and outputs after the edge.
  task automatic apply(input vec_t t);
    out_t e;
    out_t got;
    int g;
    req_valid = t.v; wb_hold = t.hold; req_addr = t.a; req_data = t.d;
    @(negedge clk);
    chk({t.name, ".ready"}, 64'(req_ready), 64'(t.rdy));
    chk({t.name, ".ready_s"}, 64'(rdy_s), 64'(t.rdy));
    e.en = 1'b0; e.addr = last_addr; e.data = last_data;
    g = -1;
    for (int i = 0; i < 3; i++) if (t.rdy[i]) g = i;
    if (g >= 0) begin
      e.addr = t.a[g*5 +: 5];
      e.data = t.d[g*32 +: 32];
      e.en   = (e.addr != 5'd0);
      last_addr = e.addr;
      last_data = e.data;
    end
    exp_q.push_back(e);
    if ($countones(t.v) >= 2) begin
      if (exp_cnt < 65535) exp_cnt++;
      if (exp_cnt4 < 15) exp_cnt4++;
    end
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk({t.name, ".en"},   64'(rf_write_en),   64'(got.en));
    chk({t.name, ".addr"}, 64'(rf_write_addr), 64'(got.addr));
    chk({t.name, ".data"}, 64'(rf_data),       64'(got.data));
    chk({t.name, ".cnt"},  64'(conflict_cnt),  64'(exp_cnt));
    chk({t.name, ".cnt4"}, 64'(cnt_s),         64'(exp_cnt4));
  endtask

  // Hold reset across one edge with requests pending; grants must stay void.
  task automatic do_reset();
    rst = 1'b1; wb_hold = 1'b0; req_valid = 3'b011; req_addr = {5'd3, 5'd2, 5'd1};
    #1;
    chk("rst.ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("rst.ready_edge", 64'(req_ready), 64'd0);
    chk("rst.en",   64'(rf_write_en),   64'd0);
    chk("rst.addr", 64'(rf_write_addr), 64'd0);
    chk("rst.data", 64'(rf_data),       64'd0);
    chk("rst.cnt",  64'(conflict_cnt),  64'd0);
    chk("rst.cnt4", 64'(cnt_s),         64'd0);
    rst = 1'b0; req_valid = '0;
    model_reset();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single request, idle, x0 discard.
    tbl_a.push_back(mk(3'b010, 0, 0, 5, 0, 0, 32'hDEADBEEF, 0, 3'b010, "single"));
    tbl_a.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, "single_after"));
    tbl_a.push_back(mk(3'b001, 0, 0, 0, 0, 0, 0, 32'h1234, 3'b001, "x0"));
    tbl_a.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, "x0_after"));

`ifdef WB_ARB_ROUND_ROBIN_EN
    tbl_b.push_back(mk(3'b111, 0, 3, 2, 1, 32'hC2, 32'hC1, 32'hC0, 3'b001, "cont0"));
    tbl_b.push_back(mk(3'b110, 0, 3, 2, 1, 32'hC2, 32'hC1, 32'hC0, 3'b010, "cont1"));
    tbl_b.push_back(mk(3'b100, 0, 3, 2, 1, 32'hC2, 32'hC1, 32'hC0, 3'b100, "cont2"));
    tbl_b.push_back(mk(3'b101, 0, 12, 0, 10, 32'hF2, 0, 32'hF0, 3'b001, "fair0"));
    tbl_b.push_back(mk(3'b101, 0, 12, 0, 10, 32'hF2, 0, 32'hF1, 3'b100, "fair1"));
    tbl_b.push_back(mk(3'b101, 0, 12, 0, 10, 32'hF3, 0, 32'hF1, 3'b001, "fair2"));
    tbl_b.push_back(mk(3'b101, 0, 12, 0, 10, 32'hF3, 0, 32'hF4, 3'b100, "fair3"));
`else
    tbl_b.push_back(mk(3'b111, 0, 3, 2, 1, 32'hC2, 32'hC1, 32'hC0, 3'b001, "cont0"));
    tbl_b.push_back(mk(3'b111, 0, 3, 2, 4, 32'hC2, 32'hC1, 32'hC4, 3'b001, "cont_preempt"));
    tbl_b.push_back(mk(3'b110, 0, 3, 2, 4, 32'hC2, 32'hC1, 32'hC4, 3'b010, "cont1"));
    tbl_b.push_back(mk(3'b100, 0, 3, 2, 4, 32'hC2, 32'hC1, 32'hC4, 3'b100, "cont2"));
    tbl_b.push_back(mk(3'b101, 0, 12, 0, 10, 32'hF2, 0, 32'hF0, 3'b001, "prio0"));
    tbl_b.push_back(mk(3'b101, 0, 12, 0, 10, 32'hF2, 0, 32'hF1, 3'b001, "prio1"));
    tbl_b.push_back(mk(3'b100, 0, 12, 0, 10, 32'hF2, 0, 32'hF1, 3'b100, "prio2"));
`endif
    // Hold for three cycles, then grant on release.
    tbl_b.push_back(mk(3'b100, 1, 17, 0, 0, 32'h0BAD0002, 0, 0, 3'b000, "hold0"));
    tbl_b.push_back(mk(3'b100, 1, 17, 0, 0, 32'h0BAD0002, 0, 0, 3'b000, "hold1"));
    tbl_b.push_back(mk(3'b100, 1, 17, 0, 0, 32'h0BAD0002, 0, 0, 3'b000, "hold2"));
    tbl_b.push_back(mk(3'b100, 0, 17, 0, 0, 32'h0BAD0002, 0, 0, 3'b100, "hold_rel"));
    // Same destination from two requesters: the later write is the last one presented.
    tbl_b.push_back(mk(3'b011, 0, 0, 9, 9, 0, 32'hA1, 32'hA0, 3'b001, "same0"));
    tbl_b.push_back(mk(3'b010, 0, 0, 9, 9, 0, 32'hA1, 32'hA0, 3'b010, "same1"));
    // Back-to-back grants to one requester.
    tbl_b.push_back(mk(3'b001, 0, 0, 0, 21, 0, 0, 32'h55550001, 3'b001, "tput0"));
    tbl_b.push_back(mk(3'b001, 0, 0, 0, 22, 0, 0, 32'h55550002, 3'b001, "tput1"));

    do_reset();
    for (int i = 0; i < tbl_a.size(); i++) apply(tbl_a[i]);

    do_reset();
    for (int i = 0; i < tbl_b.size(); i++) apply(tbl_b[i]);

    // Reset the cycle after a grant to x7: the enable must clear before any edge.
    apply(mk(3'b001, 0, 0, 0, 7, 0, 0, 32'h77, 3'b001, "mf_grant"));
    req_valid = 3'b010; req_addr = {5'd0, 5'd8, 5'd0};
    #1;
    rst = 1'b1;
    #1;
    chk("mf.en_async", 64'(rf_write_en), 64'd0);
    chk("mf.ready",    64'(req_ready),   64'd0);
    @(posedge clk);
    #1;
    chk("mf.en",   64'(rf_write_en),   64'd0);
    chk("mf.addr", 64'(rf_write_addr), 64'd0);
    rst = 1'b0; req_valid = '0;
    model_reset();

    // Contention held off by wb_hold for 20 cycles saturates the 4-bit counter.
    for (int i = 0; i < 20; i++)
      apply(mk(3'b111, 1, 3, 2, 1, 32'hE2, 32'hE1, 32'hE0, 3'b000, "sat"));
    chk("sat.cnt4_final",  64'(cnt_s),        64'd15);
    chk("sat.cnt16_final", 64'(conflict_cnt), 64'd20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and sequencer for the single write port of the integer register file. It accepts write requests from up to `NUM_REQ` producers (ALU, load unit, CSR/misc), grants one per cycle, and drives the register file's `write_en`/`write_addr`/`data` from a registered stage. Requests to x0 are acknowledged and discarded, because the register file itself does not protect x0. It sits between the execute/memory stages and the register file write port.

## Interface
- `NUM_REQ`, 3, number of write-back requesters (2..8)
- `WORD_LENGTH`, 32, data width
- `ADDR_LENGTH`, 5, register address width
- `CNT_WIDTH`, 16, width of the conflict performance counter

One clock; reset is asynchronous and active-high.

- `clk` input 1: clock, rising edge
- `rst` input 1: asynchronous, active-high reset
- `req_valid` input NUM_REQ: per-requester write request
- `req_addr` input NUM_REQ*ADDR_LENGTH: flat; requester i occupies bits [i*ADDR_LENGTH +: ADDR_LENGTH]
- `req_data` input NUM_REQ*WORD_LENGTH: flat; requester i occupies bits [i*WORD_LENGTH +: WORD_LENGTH]
- `req_ready` output NUM_REQ: one-hot-or-zero grant; combinational
- `wb_hold` input 1: when high, no grants are issued
- `rf_write_en` output 1: to register file `write_en`
- `rf_write_addr` output ADDR_LENGTH: to register file `write_addr`
- `rf_data` output WORD_LENGTH: to register file `data`
- `conflict_cnt` output CNT_WIDTH: saturating count of cycles with ≥2 valid requests

## Operation
- Handshake: a transfer occurs on any rising edge where `req_valid[i] && req_ready[i]`. Once `req_valid[i]` is asserted, the requester holds it, together with its addr and data, until the transfer. Valid is never dropped early.
- Grant: `req_ready` is all-zero when `rst`, `wb_hold`, or no valid requests. Otherwise exactly one bit is set: the selected valid requester. `req_ready[i]` never depends on `req_valid[i]` of a non-selected requester beyond the selection logic itself.
- Selection policy depends on `WB_ARB_ROUND_ROBIN_EN` (see Configuration).
- Output stage: on each edge, if a transfer occurred, the stage captures `rf_write_addr`/`rf_data` from the granted requester. In that case `rf_write_en` = (addr != 0). If no transfer occurred, `rf_write_en` = 0, and addr and data hold their previous values.
- x0 writes: the request is granted normally, but `rf_write_en` stays 0 in the following cycle.
- `conflict_cnt`: increments by 1 on each edge where popcount(`req_valid`) ≥ 2, regardless of `wb_hold`. It saturates at 2^CNT_WIDTH−1 and never wraps.
- No internal buffering beyond the single output stage. Backpressure is purely through `req_ready`.

## Timing
- Reset values: `rf_write_en`=0, `rf_write_addr`=0, `rf_data`=0, `conflict_cnt`=0, round-robin pointer=0, `req_ready`=0 while `rst` is high.
- Latency: a request granted in cycle T appears on `rf_*` in cycle T+1. The register file captures it at the edge ending cycle T+1.
- Throughput: one write per cycle. A requester with continuous valid can be granted on consecutive cycles if no other requester is valid.
- Reset mid-operation: the `rf_write_en` of an in-flight write clears immediately (async) and the write is lost. Grants issued in the cycle reset asserts are void.
- `wb_hold` asserted in cycle T: no grant in T. The output stage still presents the write granted in T−1.
- Simultaneous request to the same register from two requesters: both are eventually granted, in arbitration order. The later grant wins in the register file.

## Configuration
- `WB_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - A pointer `p` (reset 0) marks the highest-priority index.
  - Search order is p, p+1, …, wrapping modulo NUM_REQ.
  - After a transfer by requester g, p ← (g+1) mod NUM_REQ.
  - p is unchanged on cycles without a transfer.
- Not defined: fixed priority; the lowest index wins. The pointer register is not built, and starvation of high indices is permitted.

## Test plan
- Single request: req 1 valid, addr=5, data=0xDEADBEEF. Required: `req_ready`=3'b010 the same cycle; next cycle `rf_write_en`=1, addr=5, data=0xDEADBEEF; the cycle after, `rf_write_en`=0.
- x0 discard: req 0 valid, addr=0, data=0x1234. Required: `req_ready[0]`=1; next cycle `rf_write_en`=0, `rf_write_addr`=0.
- Contention: all 3 requesters held valid with addrs 1/2/3.
  - With `WB_ARB_ROUND_ROBIN_EN`: grants occur in order 0,1,2 on consecutive cycles, and `conflict_cnt`=2 after the third grant.
  - Without the macro: grants occur in order 0,1,2, but a re-raised req 0 preempts pending higher indices.
- Fairness (RR build only): req 0 and req 2 both continuously valid. Required: grants alternate 0,2,0,2 for 4 cycles.
- Hold: req 2 valid, `wb_hold`=1 for 3 cycles. Required: `req_ready`=0 and `rf_write_en`=0 throughout; grant occurs in the first cycle after hold drops.
- Reset mid-flight and saturation:
  - Assert `rst` the cycle after a grant to addr 7. Required: `rf_write_en` drops to 0 without waiting for a clock edge.
  - With CNT_WIDTH=4 and ≥2 valid requests for 20 cycles: `conflict_cnt` = 15.
